channel_corrupt: RTL
====================

// Module: channel_corrupt
// PURPOSE
//  Parametrised channel-error injector between the RM(1,4) encoder output and the decoder input.
//  Each accepted codeword is XORed with an error mask from one of four modes:
//  bypass, density-controlled random, contiguous burst, or deterministic walking single-bit.
//  Adds valid/ready flow control, reproducible per-instance LFSR seeding and saturating error/word counters.
// PARAMETERS
//  WIDTH      16            codeword width in bits (2..LFSR_W)
//  LFSR_W     32            width of each internal Galois LFSR
//  MAX_LEVEL  5             number of LFSRs = max density level
//  SEED       32'h1D872B41  base seed; LFSR i seeded SEED^(32'h9E3779B9*(i+1)), truncated to LFSR_W; all-zero -> 1
//  CNT_W      32            width of err_count / word_count
// PORTS
//  clk         in   1        clock, all logic rising-edge
//  rst         in   1        synchronous reset, active-high
//  in_valid    in   1        input codeword valid
//  in_ready    out  1        block can accept a word this cycle
//  in_data     in   WIDTH    clean codeword
//  mode        in   2        0 bypass, 1 random, 2 burst, 3 walk
//  level       in   3        random density: mask = AND of low WIDTH bits of LFSR 0..level-1
//  burst_len   in   5        burst mode: number of contiguous bits flipped
//  cnt_clr     in   1        clear err_count and word_count
//  out_valid   out  1        corrupted word valid
//  out_ready   in   1        downstream accepts
//  out_data    out  WIDTH    in_data ^ mask
//  out_mask    out  WIDTH    mask applied to out_data (for BER checking)
//  err_count   out  CNT_W    total flipped bits, saturating
//  word_count  out  CNT_W    total accepted words, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_mask=0, counters=0, walk index=0, LFSRs=seeds; in_ready=1 after reset.
//  - Handshake: in_ready = !out_valid | out_ready. Accept = in_valid & in_ready.
//    - On accept: out_data, out_mask, out_valid=1 load on the same edge (latency 1).
//    - Without a new accept, out_valid clears on out_valid & out_ready.
//    - While out_valid & !out_ready: out_data/out_mask held stable.
//  - mode/level/burst_len are sampled only on accept. Changes affect the next accepted word only.
//  - LFSRs: polynomial x^32+x^22+x^2+x+1 (taps 0x80200003), scaled to LFSR_W.
//    - Each LFSR advances WIDTH steps (unrolled) per accept only. Stalls/idle do not advance them.
//    - Mask uses pre-advance state.
//  - mode 0: mask=0.
//  - mode 1: level 0 -> mask=0. level>MAX_LEVEL clamps to MAX_LEVEL. Expected flips per word = WIDTH/2^level.
//  - mode 2:
//    - start = LFSR0[IDX_W-1:0] mod WIDTH, where IDX_W = clog2(WIDTH).
//    - Set burst_len bits from start upward, wrapping past MSB to bit 0.
//    - burst_len 0 -> mask 0. burst_len>=WIDTH -> all ones.
//  - mode 3: mask = 1<<walk_idx. walk_idx increments mod WIDTH per mode-3 accept only. Other modes leave it unchanged.
//  - Counters on accept: err_count += popcount(mask), word_count += 1. Both saturate at all-ones (no wrap).
//  - cnt_clr with simultaneous accept: counters = current word's contribution (err = popcount(mask), word = 1).
//  - Reset mid-operation: pending output dropped, all state to reset values. Next sequence identical to post-power-up.
// TESTING
//  1. Mode 0, in_data=16'hA5A5, out_ready=1 -> next cycle out_data=16'hA5A5, out_mask=0, err_count=0, word_count=1.
//  2. Mode 3, 18 words of 16'h0000 -> out_data 0001,0002,...,8000,0001,0002. err_count=18.
//  3. Mode 2:
//     - burst_len=4 -> every mask has popcount 4, contiguous mod 16, matching the reference-model LFSR start.
//     - burst_len=20 -> mask FFFF.
//     - burst_len=0 -> mask 0.
//  4. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, LFSR/counters unchanged.
//     Release -> words delivered in order, none lost or duplicated.
//  5. Mode 1, level=1..5, 4096 words each -> mask sequence bit-exact vs C model.
//     err_count approx 32768/16384/8192/4096/2048 (within 5%). level=0 -> err_count=0.
//  6. rst asserted mid-stream, then replay of test 5 level 2 -> identical mask sequence.
//     cnt_clr coincident with an accept -> err_count=popcount(that mask), word_count=1.

Source files
------------

// File: rtl/channel_corrupt.sv
// Channel-error injector: XORs each accepted codeword with a bypass, random, burst or
// walking-bit error mask, with valid/ready flow control and saturating statistics.
module channel_corrupt #(
  parameter int          WIDTH     = 16,
  parameter int          LFSR_W    = 32,
  parameter int          MAX_LEVEL = 5,
  parameter logic [31:0] SEED      = 32'h1D872B41,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [2:0]       level,
  input  logic [4:0]       burst_len,
  input  logic             cnt_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_mask,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // x^32+x^22+x^2+x+1 scaled to LFSR_W (0x80200003 at 32 bits)
  localparam logic [LFSR_W-1:0] TAPS = (LFSR_W'(1) << (LFSR_W - 1)) |
                                       (LFSR_W'(1) << ((LFSR_W * 21) / 32)) | LFSR_W'(3);
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [LFSR_W-1:0] seed_f(input int idx);
    logic [31:0]       s;
    logic [LFSR_W-1:0] t;
    s = SEED ^ (32'h9E3779B9 * 32'(idx + 1));
    t = s[LFSR_W-1:0];
    return (t == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : t;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = s;
    for (int k = 0; k < WIDTH; k++) begin
      if (r[0]) r = (r >> 1) ^ TAPS;
      else      r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < WIDTH; k++) c = c + CNT_W'(m[k]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [LFSR_W-1:0] lfsr_r [MAX_LEVEL];
  logic [IDX_W-1:0]  walk_r;
  logic [IDX_W-1:0]  walk_nxt_s;
  logic [WIDTH-1:0]  rnd_s, burst_s, walk_s, mask_s;
  logic [CNT_W-1:0]  pop_s;
  logic              accept_s;

  assign in_ready   = !out_valid | out_ready;
  assign accept_s   = in_valid & in_ready;
  assign pop_s      = popcount(mask_s);
  assign walk_nxt_s = (walk_r == IDX_W'(WIDTH - 1)) ? '0 : walk_r + IDX_W'(1);

  // Mask generation from the pre-advance LFSR state and the walk index.
  always_comb begin
    int lvl_v;
    int start_v;
    int off_v;
    lvl_v = (int'(level) > MAX_LEVEL) ? MAX_LEVEL : int'(level);
    rnd_s = '1;
    for (int i = 0; i < MAX_LEVEL; i++) begin
      if (i < lvl_v) rnd_s = rnd_s & lfsr_r[i][WIDTH-1:0];
      else           rnd_s = rnd_s;
    end
    if (lvl_v == 0) rnd_s = '0;
    else            rnd_s = rnd_s;
    start_v = int'(lfsr_r[0][IDX_W-1:0]) % WIDTH;
    burst_s = '0;
    // bit j is in the burst when its distance above start (mod WIDTH) is below burst_len
    for (int j = 0; j < WIDTH; j++) begin
      off_v = (j + WIDTH - start_v) % WIDTH;
      if (off_v < int'(burst_len)) burst_s[j] = 1'b1;
      else                         burst_s[j] = 1'b0;
    end
    walk_s = ONE_W << walk_r;
    case (mode)
      2'd0:    mask_s = '0;
      2'd1:    mask_s = rnd_s;
      2'd2:    mask_s = burst_s;
      2'd3:    mask_s = walk_s;
      default: mask_s = '0;
    endcase
  end

  // Output register, LFSR bank and walk index; all move only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      walk_r    <= '0;
      for (int i = 0; i < MAX_LEVEL; i++) lfsr_r[i] <= seed_f(i);
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ mask_s;
      out_mask  <= mask_s;
      for (int i = 0; i < MAX_LEVEL; i++) lfsr_r[i] <= lfsr_adv(lfsr_r[i]);
      if (mode == 2'd3) walk_r <= walk_nxt_s;
      else              walk_r <= walk_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Saturating statistics; a clear coincident with an accept keeps that word's contribution.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count  <= '0;
      word_count <= '0;
    end else if (cnt_clr) begin
      err_count  <= accept_s ? pop_s : '0;
      word_count <= accept_s ? ONE_CNT : '0;
    end else if (accept_s) begin
      err_count  <= sat_add(err_count, pop_s);
      word_count <= sat_add(word_count, ONE_CNT);
    end else begin
      err_count  <= err_count;
      word_count <= word_count;
    end
  end

endmodule
